// File: rtl/mux_pipe_blank_pkg.sv
// Shared definitions for the mux_pipe_blank selector.
// Holds the two-state FSM encoding, the default parameter set and a helper
// that sizes the blanking down-counter.
package mux_pipe_blank_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_BLANK = 2;
  localparam int DEF_CNT_W = 16;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_pipe_blank_valid_pipe.sv
// DEPTH-stage {valid,data} shift register with asynchronous active-high reset.
// Every stage shifts on every clock; there is no stall. A stage only captures
// data when the incoming valid is set, so the last stage's data holds its
// previous sample while invalid slots pass through.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   stage-1 valid
//   in_data   in   stage-1 data (WIDTH bits)
//   out_valid out  final-stage valid
//   out_data  out  final-stage data (WIDTH bits)
module mux_pipe_blank_valid_pipe
  import mux_pipe_blank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift valid bits every cycle; move data only alongside a valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mux_pipe_blank.sv
// Registered N-channel W-bit data selector with post-switch blanking.
// After any select change, BLANK consecutive clock edges (the change edge
// included) drop their samples; accepted samples travel a DEPTH-stage
// pipeline and appear for one cycle on dout/out_valid.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   din       in   NCH*WIDTH flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel       in   channel select (SEL_W bits)
//   in_valid  in   din qualifier
//   dout      out  selected data, holds between valid samples
//   out_valid out  dout carries a new sample this cycle
//   busy      out  blanking window active
//   sel_err   out  sticky flag: a select >= NCH was seen
//   sw_cnt    out  saturating count of select changes (CNT_W bits)
module mux_pipe_blank
  import mux_pipe_blank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BLANK = DEF_BLANK,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   dout,
  output logic               out_valid,
  output logic               busy,
  output logic               sel_err,
  output logic [CNT_W-1:0]   sw_cnt
);

  localparam int               BW           = cnt_width(BLANK);
  localparam logic [BW-1:0]    BLANK_RELOAD = BW'(BLANK - 1);
  localparam logic [SEL_W:0]   NCH_LIM      = (SEL_W + 1)'(NCH);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic [BW-1:0]    blank_cnt;
  logic [BW-1:0]    blank_cnt_next;
  logic [SEL_W-1:0] sel_q;
  logic             change;
  logic             sel_oob;
  logic             accept;
  logic [WIDTH-1:0] mux_data;

  // Change detect and channel mux; the new select is sel itself, so the mux
  // already follows the select being loaded on this edge.
  always_comb begin
    change  = (sel != sel_q);
    sel_oob = ({1'b0, sel} >= NCH_LIM);
    if (sel_oob) begin
      mux_data = {WIDTH{1'b0}};
    end else begin
      mux_data = din[sel*WIDTH +: WIDTH];
    end
  end

  // FSM state register and blanking down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      blank_cnt <= {BW{1'b0}};
    end else begin
      state     <= state_next;
      blank_cnt <= blank_cnt_next;
    end
  end

  // FSM next state: a change (re)opens the window; in BLANK the counter
  // runs down and the edge that sees it at zero returns to RUN.
  always_comb begin
    state_next     = state;
    blank_cnt_next = blank_cnt;
    if (change) begin
      state_next     = ST_BLANK;
      blank_cnt_next = BLANK_RELOAD;
    end else begin
      case (state)
        ST_RUN: begin
          state_next = ST_RUN;
        end
        ST_BLANK: begin
          if (blank_cnt == {BW{1'b0}}) begin
            state_next = ST_RUN;
          end else begin
            blank_cnt_next = blank_cnt - BW'(1);
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // FSM outputs. The edge that closes the window (BLANK with counter at zero)
  // already accepts, so exactly BLANK edges are dropped per change.
  always_comb begin
    busy = (state == ST_BLANK);
    if (state == ST_RUN) begin
      accept = in_valid & ~change;
    end else if (blank_cnt == {BW{1'b0}}) begin
      accept = in_valid & ~change;
    end else begin
      accept = 1'b0;
    end
  end

  // Select register, saturating change counter and sticky range error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= {SEL_W{1'b0}};
      sw_cnt  <= {CNT_W{1'b0}};
      sel_err <= 1'b0;
    end else begin
      sel_q <= sel;
      if (change && (sw_cnt != CNT_MAX)) begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
      if (sel_oob) begin
        sel_err <= 1'b1;
      end
    end
  end

  mux_pipe_blank_valid_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_data  (mux_data),
    .out_valid(out_valid),
    .out_data (dout)
  );

endmodule

// File: tb/tb_mux_pipe_blank.sv
// Self-checking bench for mux_pipe_blank. Two instances share the stimulus:
// u_def uses the default parameters, u_alt uses NCH=3 and CNT_W=4 so that an
// out-of-range select and counter saturation can be exercised.
module tb_mux_pipe_blank;

  localparam int DEPTH = 2;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = 32'h0;
  logic [1:0]  sel = 2'd0;
  logic        in_valid = 1'b0;

  logic [7:0]  dout_d, dout_a;
  logic        ov_d, ov_a, busy_d, busy_a, err_d, err_a;
  logic [15:0] cnt_d;
  logic [3:0]  cnt_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_pipe_blank #(.WIDTH(8), .NCH(4), .SEL_W(2), .DEPTH(DEPTH), .BLANK(BLANK), .CNT_W(16)) u_def (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .in_valid(in_valid),
    .dout(dout_d), .out_valid(ov_d), .busy(busy_d), .sel_err(err_d), .sw_cnt(cnt_d)
  );

  mux_pipe_blank #(.WIDTH(8), .NCH(3), .SEL_W(2), .DEPTH(DEPTH), .BLANK(BLANK), .CNT_W(4)) u_alt (
    .clk(clk), .rst(rst), .din(din[23:0]), .sel(sel), .in_valid(in_valid),
    .dout(dout_a), .out_valid(ov_a), .busy(busy_a), .sel_err(err_a), .sw_cnt(cnt_a)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, the number of window edges still to
  // drop, the sticky flag, the saturating count and a delay line of results.
  int m_sel [2], m_left [2], m_cnt [2], m_err [2];
  int m_busy [2], m_ov [2], m_dout [2];
  int dl [2][8];
  int ecount = 0;

  // Inputs change only just after a falling edge, so the values seen here are
  // the ones sampled by the rising edge that just happened.
  always @(negedge clk) begin
    int nch, cmax, s, data, o;
    bit win, acc;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_sel[k] = 0; m_left[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
        m_busy[k] = 0; m_ov[k] = 0; m_dout[k] = 0;
        for (int j = 0; j < 8; j++) dl[k][j] = 0;
      end
      ecount = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        nch  = (k == 0) ? 4 : 3;
        cmax = (k == 0) ? 65535 : 15;
        s    = int'(sel);
        if (s != m_sel[k]) begin
          m_sel[k] = s;
          if (m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
          m_left[k] = BLANK;
        end
        win = (m_left[k] > 0);
        if (win) m_left[k] = m_left[k] - 1;
        acc = in_valid && !win;
        if (s < nch) begin
          data = int'((din >> (s * 8)) & 32'hFF);
        end else begin
          data = 0;
          m_err[k] = 1;
        end
        m_busy[k] = win ? 1 : 0;
        dl[k][ecount % 8] = acc ? (256 + data) : 0;
        o = dl[k][(ecount + 8 - (DEPTH - 1)) % 8];
        m_ov[k] = (o >= 256) ? 1 : 0;
        if (o >= 256) m_dout[k] = o - 256;
      end
      ecount++;
    end
    chk("m_dout_def", dout_d, m_dout[0]);
    chk("m_ov_def",   ov_d,   m_ov[0]);
    chk("m_busy_def", busy_d, m_busy[0]);
    chk("m_err_def",  err_d,  m_err[0]);
    chk("m_cnt_def",  cnt_d,  m_cnt[0]);
    chk("m_dout_alt", dout_a, m_dout[1]);
    chk("m_ov_alt",   ov_a,   m_ov[1]);
    chk("m_busy_alt", busy_a, m_busy[1]);
    chk("m_err_alt",  err_a,  m_err[1]);
    chk("m_cnt_alt",  cnt_a,  m_cnt[1]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    chk("rst_dout", dout_d, 8'h00);
    chk("rst_ov", ov_d, 1'b0);
    chk("rst_busy", busy_d, 1'b0);
    chk("rst_cnt", cnt_d, 16'd0);
    chk("rst_err", err_a, 1'b0);
    rst = 1'b0;

    // ch3=3C ch2=C3 ch1=11 ch0=5A
    din = 32'h3CC3_115A; sel = 2'd0; in_valid = 1'b1;
    tick();
    chk("lat_not_yet", ov_d, 1'b0);
    tick();
    chk("steady_dout", dout_d, 8'h5A);
    chk("steady_ov", ov_d, 1'b1);
    tick();
    chk("steady_ov2", ov_d, 1'b1);

    // Isolated change 0->2
    sel = 2'd2;
    tick();
    chk("iso_busy0", busy_d, 1'b1);
    chk("iso_cnt", cnt_d, 16'd1);
    chk("iso_dout0", dout_d, 8'h5A);
    tick();
    chk("iso_busy1", busy_d, 1'b1);
    chk("iso_ov1", ov_d, 1'b0);
    tick();
    chk("iso_busy2", busy_d, 1'b0);
    chk("iso_ov2", ov_d, 1'b0);
    chk("iso_hold", dout_d, 8'h5A);
    tick();
    chk("iso_dout", dout_d, 8'hC3);
    chk("iso_ov3", ov_d, 1'b1);
    chk("iso_dout_alt", dout_a, 8'hC3);

    // Re-change inside the window: 2->1 then 1->3
    sel = 2'd1;
    tick();
    sel = 2'd3;
    tick();
    chk("re_cnt", cnt_d, 16'd3);
    chk("re_busy1", busy_d, 1'b1);
    tick();
    chk("re_busy2", busy_d, 1'b1);
    tick();
    chk("re_busy3", busy_d, 1'b0);
    chk("re_ov3", ov_d, 1'b0);
    tick();
    chk("re_dout", dout_d, 8'h3C);
    chk("re_ov4", ov_d, 1'b1);
    chk("oob_dout", dout_a, 8'h00);
    chk("oob_ov", ov_a, 1'b1);
    chk("oob_err", err_a, 1'b1);
    chk("oob_err_def", err_d, 1'b0);

    // Back to channel 0; error stays sticky
    sel = 2'd0;
    tick(); tick(); tick(); tick();
    chk("sticky_err", err_a, 1'b1);
    chk("back_dout", dout_d, 8'h5A);
    chk("back_cnt", cnt_d, 16'd4);

    // Gap in in_valid: output goes quiet and dout holds
    in_valid = 1'b0; din[7:0] = 8'h77;
    tick(); tick();
    chk("gap_ov", ov_d, 1'b0);
    chk("gap_hold", dout_d, 8'h5A);
    in_valid = 1'b1;
    tick(); tick();
    chk("gap_resume", dout_d, 8'h77);

    // 20 changes: alt counter saturates at 15, blanking on every change
    for (int i = 0; i < 20; i++) begin
      sel = (i % 2 == 0) ? 2'd1 : 2'd0;
      tick();
      chk("sat_busy", busy_a, 1'b1);
    end
    chk("sat_cnt_alt", cnt_a, 4'd15);
    chk("sat_cnt_def", cnt_d, 16'd24);
    tick(); tick();
    chk("sat_busy_end", busy_a, 1'b0);
    tick();
    chk("sat_dout", dout_a, 8'h77);
    sel = 2'd2;
    tick();
    chk("sat_busy_again", busy_a, 1'b1);
    chk("sat_hold", cnt_a, 4'd15);
    tick(); tick(); tick();
    chk("sat_new_dout", dout_a, 8'hC3);

    // Asynchronous reset mid-cycle with samples in flight
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", dout_d, 8'h00);
    chk("arst_ov", ov_d, 1'b0);
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_cnt", cnt_a, 4'd0);
    chk("arst_err", err_a, 1'b0);
    sel = 2'd0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_ov", ov_d, 1'b0);
    chk("post_rst_dout", dout_d, 8'h00);
    in_valid = 1'b1;
    tick(); tick();
    chk("post_rst_new", dout_d, 8'h77);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
